// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
//   fetch_entry_t    - prefetch buffer entry {pc, inst}; pc is stored at full 32-bit width
//                      so the struct is independent of the fetch unit's ADDR_W.
//   ENTRY_W          - packed width of fetch_entry_t.
//   DEFAULT_RESET_PC - default fetch address loaded on reset.
//   INST_NOP         - canonical no-op encoding (addi x0, x0, 0).
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W          = $bits(fetch_entry_t);
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch buffer of DEPTH fetch_entry_t entries (DEPTH a power of two, >= 2).
// Ports:
//   clk, reset_n  - clock and synchronous active-low reset (empties the buffer).
//   flush         - discards all entries; has priority over push and pop.
//   push, wdata   - write one entry; ignored when full unless a pop happens in the same cycle.
//   pop           - remove the head entry; ignored when empty.
//   rdata         - head entry, read straight from registers; all-zero while empty.
//   full, empty   - occupancy flags.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               push,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic               pop,
    output logic [ENTRY_W-1:0] rdata,
    output logic               full,
    output logic               empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [PTR_W:0]   count_q;

    logic do_push;
    logic do_pop;

    assign full  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty = (count_q == '0);

    // A push into a full buffer is legal when the head leaves in the same cycle.
    assign do_push = push && (!full || pop) && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Gate the head so stale storage never shows while the buffer is empty.
    assign rdata = empty ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= fetch_entry_t'(wdata);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with a small prefetch buffer and redirect support.
// Optional feature macro: IF_MISALIGN_CHECK_EN (misaligned-redirect flag).
// Ports:
//   clk, reset_n      - clock and synchronous active-low reset.
//   imem_addr         - fetch PC driven to the instruction ROM.
//   imem_inst         - combinational ROM data for imem_addr.
//   redirect_valid    - branch/jump redirect; flushes the buffer and reloads the PC.
//   redirect_target   - redirect byte address; low two bits are dropped.
//   if_valid/if_ready - decode handshake on the buffer head.
//   if_inst, if_pc    - head instruction and its address (zero while empty).
//   fetch_misaligned  - one-cycle pulse after a redirect with a non-word-aligned target.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int unsigned       DEPTH    = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic              fetch_misaligned
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] aligned_target;

    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    fetch_entry_t wentry;
    fetch_entry_t head;
    logic         unused_head_pc;

    assign imem_addr      = pc_q;
    assign aligned_target = redirect_target & ~ADDR_W'(3);

    // Redirect wins over the handshake; otherwise fetch whenever a slot is or becomes free.
    assign pop  = !empty && if_ready && !redirect_valid;
    assign push = !redirect_valid && (!full || pop);

    assign wentry.pc   = 32'(pc_q);
    assign wentry.inst = imem_inst;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = aligned_target;
        end else if (push) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (redirect_valid),
        .push    (push),
        .wdata   (wentry),
        .pop     (pop),
        .rdata   (head),
        .full    (full),
        .empty   (empty)
    );

    assign if_valid = !empty;
    assign if_inst  = head.inst;
    assign if_pc    = head.pc[ADDR_W-1:0];

    // Upper stored pc bits above ADDR_W are always zero.
    assign unused_head_pc = ^head.pc;

`ifdef IF_MISALIGN_CHECK_EN
    logic misaligned_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= redirect_valid && (redirect_target[1:0] != 2'b00);
        end
    end

    assign fetch_misaligned = misaligned_q;
`else
    assign fetch_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit (default parameters).
// The ROM returns {20'hABCDE, addr}, so every expected instruction is a hand-written constant.
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic [11:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [11:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [11:0] if_pc;
    logic        fetch_misaligned;

    int checks;
    int failures;

`ifdef IF_MISALIGN_CHECK_EN
    localparam logic EXP_MIS = 1'b1;
`else
    localparam logic EXP_MIS = 1'b0;
`endif

    fetch_unit dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .imem_addr        (imem_addr),
        .imem_inst        (imem_inst),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .if_valid         (if_valid),
        .if_ready         (if_ready),
        .if_inst          (if_inst),
        .if_pc            (if_pc),
        .fetch_misaligned (fetch_misaligned)
    );

    assign imem_inst = {20'hABCDE, imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge; outputs are sampled and inputs driven there.
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset_n         = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 12'h000;
        if_ready        = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_inst", if_inst, 32'h0);
        check("rst_pc", 32'(if_pc), 32'h0);
        check("rst_mis", 32'(fetch_misaligned), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'h000);

        // Fill after reset release, one per cycle
        reset_n = 1'b1;
        check("fill_valid0", 32'(if_valid), 32'd0);
        tick();
        check("fill_valid1", 32'(if_valid), 32'd1);
        check("fill_pc0", 32'(if_pc), 32'h000);
        check("fill_inst0", if_inst, 32'hABCDE000);
        tick();
        check("fill_pc1", 32'(if_pc), 32'h004);
        check("fill_inst1", if_inst, 32'hABCDE004);
        tick();
        check("fill_pc2", 32'(if_pc), 32'h008);
        check("fill_inst2", if_inst, 32'hABCDE008);

        // Back-pressure from reset: two entries held, fetch stalls at 0x008
        reset_n  = 1'b0;
        if_ready = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        check("bp_valid", 32'(if_valid), 32'd1);
        check("bp_pc", 32'(if_pc), 32'h000);
        check("bp_addr", 32'(imem_addr), 32'h008);
        if_ready = 1'b1;
        tick();
        check("bp_pc1", 32'(if_pc), 32'h004);
        tick();
        check("bp_pc2", 32'(if_pc), 32'h008);
        tick();
        check("bp_pc3", 32'(if_pc), 32'h00C);
        check("bp_inst3", if_inst, 32'hABCDE00C);

        // Redirect from a full buffer
        if_ready = 1'b0;
        tick();
        tick();
        check("full_addr", 32'(imem_addr), 32'h014);
        redirect_valid  = 1'b1;
        redirect_target = 12'h040;
        tick();
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        check("rd_valid", 32'(if_valid), 32'd0);
        check("rd_addr", 32'(imem_addr), 32'h040);
        check("rd_mis_al", 32'(fetch_misaligned), 32'd0);
        tick();
        check("rd_valid1", 32'(if_valid), 32'd1);
        check("rd_pc", 32'(if_pc), 32'h040);
        check("rd_inst", if_inst, 32'hABCDE040);

        // Misaligned redirect
        redirect_valid  = 1'b1;
        redirect_target = 12'h042;
        tick();
        redirect_valid = 1'b0;
        check("mis_valid", 32'(if_valid), 32'd0);
        check("mis_addr", 32'(imem_addr), 32'h040);
        check("mis_flag", 32'(fetch_misaligned), 32'(EXP_MIS));
        tick();
        check("mis_flag_off", 32'(fetch_misaligned), 32'd0);
        check("mis_pc", 32'(if_pc), 32'h040);

        // Address wrap
        redirect_valid  = 1'b1;
        redirect_target = 12'hFF8;
        tick();
        redirect_valid = 1'b0;
        check("wrap_valid", 32'(if_valid), 32'd0);
        tick();
        check("wrap_pc0", 32'(if_pc), 32'hFF8);
        tick();
        check("wrap_pc1", 32'(if_pc), 32'hFFC);
        tick();
        check("wrap_pc2", 32'(if_pc), 32'h000);
        check("wrap_inst2", if_inst, 32'hABCDE000);
        check("wrap_mis", 32'(fetch_misaligned), 32'd0);

        // Mid-stream reset with entries held; reset overrides a concurrent redirect
        if_ready = 1'b0;
        tick();
        tick();
        check("mrst_pre_valid", 32'(if_valid), 32'd1);
        reset_n         = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 12'h100;
        if_ready        = 1'b1;
        tick();
        reset_n        = 1'b1;
        redirect_valid = 1'b0;
        check("mrst_valid", 32'(if_valid), 32'd0);
        check("mrst_addr", 32'(imem_addr), 32'h000);
        check("mrst_pc", 32'(if_pc), 32'h000);
        check("mrst_inst", if_inst, 32'h0);
        tick();
        check("mrst_pc0", 32'(if_pc), 32'h000);
        check("mrst_inst0", if_inst, 32'hABCDE000);
        tick();
        check("mrst_pc1", 32'(if_pc), 32'h004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
